fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_if_id_reg.sv | 42 ++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions: reset vector, NOP encoding, fetch FSM states
// and the redirect priority helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // JR beats J/JAL beats a taken branch; otherwise fall through.
  function automatic logic [31:0] select_next_pc(
    input logic        jr,
    input logic [31:0] jrTarget,
    input logic        jump,
    input logic [31:0] jumpTarget,
    input logic        branch,
    input logic [31:0] branchTarget,
    input logic [31:0] fallThrough
  );
    if (jr)          return jrTarget;
    else if (jump)   return jumpTarget;
    else if (branch) return branchTarget;
    else             return fallThrough;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline boundary register with load, hold and flush-to-NOP; shared by the
// pipeline stage boundaries.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus_4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus_4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pcPlus4_q;
  logic        valid_q;

  // Flush wins over load; neither means hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcPlus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q   <= NOP_INSTR;
      pcPlus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcPlus4_q <= pc_plus_4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o     = instr_q;
  assign pc_plus_4_o = pcPlus4_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request/response handshake to instruction
// memory, decode-stall buffering, redirect draining and the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcD,
  input  logic [31:0] branch_target,
  input  logic        jumpD,
  input  logic [31:0] jump_target,
  input  logic        jrD,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus_4_decoded,
  output logic        validD,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         pending_q, pending_d;
  logic         started_q;
  logic [31:0]  bufInstr_q, bufInstr_d;
  logic [31:0]  bufPc4_q, bufPc4_d;

  logic         fire;
  logic         redirect;
  logic [31:0]  pcPlus4;
  logic [31:0]  redirectTarget;
  logic [31:0]  nextPc;
  logic         ifidLoad;
  logic [31:0]  ifidInstr;
  logic [31:0]  ifidPc4;

  // started_q keeps the request low until the first edge after reset release,
  // so a stray ack during or just after reset is never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      pending_q  <= 1'b0;
      started_q  <= 1'b0;
      bufInstr_q <= NOP_INSTR;
      bufPc4_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
      started_q  <= 1'b1;
      bufInstr_q <= bufInstr_d;
      bufPc4_q   <= bufPc4_d;
    end
  end

  always_comb begin
    pcPlus4        = pc_q + 32'd4;
    redirect       = ~stallD & (jrD | jumpD | pcsrcD);
    redirectTarget = select_next_pc(jrD, jr_target, jumpD, jump_target,
                                    pcsrcD, branch_target, pcPlus4);
    nextPc         = redirect ? redirectTarget : pcPlus4;

    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = imem_addr;
    pending_d  = imem_req & ~imem_ack;
    bufInstr_d = bufInstr_q;
    bufPc4_d   = bufPc4_q;
    ifidLoad   = 1'b0;
    ifidInstr  = imem_rdata;
    ifidPc4    = pcPlus4;

    unique case (state_q)
      FETCH: begin
        if (fire) begin
          if (flushD) begin
            pc_d = nextPc;
          end else if (stallD) begin
            bufInstr_d = imem_rdata;
            bufPc4_d   = pcPlus4;
            state_d    = HOLD;
          end else begin
            ifidLoad = 1'b1;
            pc_d     = nextPc;
          end
        end else if (redirect) begin
          // A redirect is never lost, even when stallF suppressed the request.
          pc_d = redirectTarget;
          if (imem_req) state_d = DRAIN;
        end
      end
      HOLD: begin
        ifidInstr = bufInstr_q;
        ifidPc4   = bufPc4_q;
        if (flushD || !stallD) begin
          ifidLoad = ~flushD;
          pc_d     = nextPc;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirectTarget;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      FETCH:   imem_req = started_q & (~stallF | pending_q);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    imem_addr  = pending_q ? addr_q : pc_q;
    fetch_busy = imem_req & ~imem_ack;
    fire       = (state_q == FETCH) & imem_req & imem_ack;
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ifidLoad),
    .flush_i     (flushD),
    .instr_i     (ifidInstr),
    .pc_plus_4_i (ifidPc4),
    .instr_o     (instrD),
    .pc_plus_4_o (pc_plus_4_decoded),
    .valid_o     (validD)
  );

endmodule
